// File: rtl/heartbeat_pwm.sv
// heartbeat_pwm: PWM-gates the LED selector mask with a two-beat "lub-dub" duty envelope.
// Define LED_ACTIVE_LOW_EN for inverted (active-low) led_out drive.
module heartbeat_pwm #(
   parameter int PWM_BITS     = 8,
   parameter int STEP_PERIODS = 4,
   parameter int DUTY_INC     = 32,
   parameter int GAP_STEPS    = 4,
   parameter int REST_STEPS   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          led_select,
   output logic [7:0]          led_out,
   output logic [PWM_BITS-1:0] duty,
   output logic                beat
);
   localparam int MAX  = 2**PWM_BITS - 1;
   localparam int HALF = MAX >> 1;
   localparam int PW   = STEP_PERIODS > 1 ? $clog2(STEP_PERIODS) : 1;
   localparam int SW   = $clog2((GAP_STEPS > REST_STEPS ? GAP_STEPS : REST_STEPS) + 1);
   localparam logic [PWM_BITS-1:0] D_MAX  = PWM_BITS'(MAX);
   localparam logic [PWM_BITS-1:0] D_HALF = PWM_BITS'(HALF);
   localparam logic [PWM_BITS-1:0] D_INC  = PWM_BITS'(DUTY_INC);
`ifdef LED_ACTIVE_LOW_EN
   localparam logic [7:0] LED_INV = 8'hFF;
`else
   localparam logic [7:0] LED_INV = 8'h00;
`endif
   typedef enum logic [2:0] {RISE1, FALL1, GAP, RISE2, FALL2, REST} state_e;
   state_e              state_q, state_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, duty_q, duty_d;
   logic [PW-1:0]       per_cnt_q;
   logic [SW-1:0]       stp_cnt_q, stp_cnt_d;
   logic [7:0]          sel_q, led_q;
   logic                beat_q, beat_d, boundary, step_tick;
   assign boundary  = &pwm_cnt_q;
   assign step_tick = boundary && per_cnt_q == PW'(STEP_PERIODS - 1);
   // Comparisons precede every add/subtract so duty saturates instead of wrapping.
   always_comb begin
      state_d   = state_q;
      duty_d    = duty_q;
      stp_cnt_d = stp_cnt_q;
      beat_d    = 1'b0;
      if (step_tick) begin
         case (state_q)
            RISE1: begin
               duty_d  = duty_q > D_MAX - D_INC ? D_MAX : duty_q + D_INC;
               state_d = duty_q > D_MAX - D_INC ? FALL1 : RISE1;
            end
            FALL1: begin
               duty_d  = duty_q < D_INC ? '0 : duty_q - D_INC;
               state_d = duty_q < D_INC ? GAP : FALL1;
            end
            GAP: begin
               stp_cnt_d = stp_cnt_q == SW'(GAP_STEPS - 1) ? '0 : stp_cnt_q + 1'b1;
               state_d   = stp_cnt_q == SW'(GAP_STEPS - 1) ? RISE2 : GAP;
            end
            RISE2: begin
               duty_d  = duty_q > D_HALF - D_INC ? D_HALF : duty_q + D_INC;
               state_d = duty_q > D_HALF - D_INC ? FALL2 : RISE2;
            end
            FALL2: begin
               duty_d  = duty_q < D_INC ? '0 : duty_q - D_INC;
               state_d = duty_q < D_INC ? REST : FALL2;
            end
            REST: begin
               stp_cnt_d = stp_cnt_q == SW'(REST_STEPS - 1) ? '0 : stp_cnt_q + 1'b1;
               state_d   = stp_cnt_q == SW'(REST_STEPS - 1) ? RISE1 : REST;
               beat_d    = stp_cnt_q == SW'(REST_STEPS - 1);
            end
            default: state_d = RISE1;
         endcase
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q <= '0;
         per_cnt_q <= '0;
         stp_cnt_q <= '0;
         duty_q    <= '0;
         state_q   <= RISE1;
         sel_q     <= '0;
         led_q     <= LED_INV;
         beat_q    <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         per_cnt_q <= boundary ? (step_tick ? '0 : per_cnt_q + 1'b1) : per_cnt_q;
         stp_cnt_q <= stp_cnt_d;
         duty_q    <= duty_d;
         state_q   <= state_d;
         sel_q     <= boundary ? led_select : sel_q;
         led_q     <= (sel_q & {8{pwm_cnt_q < duty_q}}) ^ LED_INV;
         beat_q    <= beat_d;
      end
   end
   assign led_out = led_q;
   assign duty    = duty_q;
   assign beat    = beat_q;
endmodule

// File: tb/tb_heartbeat_pwm.sv
// tb_heartbeat_pwm: directed checks of heartbeat_pwm against a hand-written duty table
// and a cycle model of the PWM/selector path.
module tb_heartbeat_pwm;
`ifdef LED_ACTIVE_LOW_EN
   localparam logic [7:0] INV = 8'hFF;
`else
   localparam logic [7:0] INV = 8'h00;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] led_select = 8'h01;
   logic [7:0] led_out;
   logic [7:0] duty;
   logic       beat;
   int n_chk = 0, n_err = 0;
   int cyc, exp_d, led_mis, beat_mis, beat_at, beat_cnt, n_on, n_full;
   logic [7:0] exp_selq, other_or;
   int tbl[44] = '{32, 64, 96, 128, 160, 192, 224, 255, 223, 191, 159, 127, 95, 63, 31, 0,
                   0, 0, 0, 0, 32, 64, 96, 127, 95, 63, 31, 0,
                   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   heartbeat_pwm dut (
      .clk(clk), .rst_n(rst_n), .led_select(led_select),
      .led_out(led_out), .duty(duty), .beat(beat)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_on = 0; n_full = 0; other_or = 8'h00;
   endtask

   task automatic model_reset();
      cyc = 0; exp_d = 0; exp_selq = 8'h00;
      led_mis = 0; beat_mis = 0; beat_at = -1; beat_cnt = 0;
      clr();
   endtask

   // Advance n clocks; the bench's own duty table and selector model predict each output.
   task automatic run(input int n);
      logic [7:0] el, lg;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         el = ((cyc - 1) % 256 < exp_d) ? exp_selq : 8'h00;
         if (cyc % 256 == 0) exp_selq = led_select;
         if (cyc % 1024 == 0) begin
            exp_d = tbl[((cyc / 1024) - 1) % 44];
            check("duty_step", int'(duty), exp_d);
         end
         if (led_out !== (el ^ INV)) led_mis++;
         if (beat !== (cyc % 45056 == 0)) beat_mis++;
         if (beat) begin beat_at = cyc; beat_cnt++; end
         lg = led_out ^ INV;
         if (lg[2]) n_on++;
         if (lg == 8'hFF) n_full++;
         other_or |= lg & 8'hFB;
      end
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      // reset state
      #3;
      check("rst_led", int'(led_out), int'(INV));
      check("rst_duty", int'(duty), 0);
      check("rst_beat", int'(beat), 0);
      @(negedge clk);
      release_rst();
      // full envelope plus start of the second heartbeat
      run(1023);
      check("first_step_wait", int'(duty), 0);
      run(45056 + 2048 - 1023);
      check("beat_count", beat_cnt, 1);
      check("beat_at", beat_at, 45056);
      check("duty_repeat", int'(duty), 64);
      // selector change at pwm_cnt 10; old pulse completes, new LED waits for the wrap
      run(10);
      led_select = 8'h02;
      run(50);
      check("sel_old_pulse", int'(led_out ^ INV), 8'h01);
      run(196);
      check("sel_wrap_edge", int'(led_out ^ INV), 8'h00);
      run(1);
      check("sel_new_start", int'(led_out ^ INV), 8'h02);
      check("led_model_a", led_mis, 0);
      check("beat_model_a", beat_mis, 0);
      // reset mid-envelope in FALL1 at duty 159
      rst_n = 1'b0;
      led_select = 8'h01;
      #1;
      rst_n = 1'b1;
      release_rst();
      run(11300);
      check("pre_rst_duty", int'(duty), 159);
      check("pre_rst_led", int'(led_out ^ INV), 8'h01);
      rst_n = 1'b0;
      #1;
      check("async_led", int'(led_out), int'(INV));
      check("async_duty", int'(duty), 0);
      check("async_beat", int'(beat), 0);
      release_rst();
      run(1023);
      check("post_rst_hold", int'(duty), 0);
      run(1);
      check("post_rst_first", int'(duty), 32);
      // PWM shape at duty 96 on LED 2
      led_select = 8'h04;
      run(3072 - cyc);
      clr();
      run(1);
      check("pwm_first_on", int'(led_out ^ INV), 8'h04);
      run(95);
      check("pwm_last_on", int'(led_out ^ INV), 8'h04);
      run(1);
      check("pwm_first_off", int'(led_out ^ INV), 8'h00);
      run(159);
      check("pwm_on_count", n_on, 96);
      check("pwm_other_bits", int'(other_or), 0);
      // all LEDs at duty MAX
      led_select = 8'hFF;
      run(8192 - cyc);
      clr();
      run(256);
      check("max_full_count", n_full, 255);
      // empty mask: LEDs dark while the envelope keeps stepping
      led_select = 8'h00;
      run(8704 - cyc);
      clr();
      run(10240 - cyc);
      check("mask0_dark", int'(other_or) | n_on, 0);
      check("mask0_duty", int'(duty), 191);
      check("led_model_b", led_mis, 0);
      check("beat_model_b", beat_mis, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
